// File: rtl/decode_rr_scheduler.sv
// Round-robin scheduler sharing one 4-to-10 one-hot decoder between 10 requesters.
// Drives the decoder code (k+1 for channel k, 0 = none) and holds each grant until release.
module decode_rr_scheduler #(
  parameter int MAX_HOLD = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  input  logic [9:0] i_req,
  input  logic       i_done,
  output logic [3:0] o_code,
  output logic       o_grant_valid,
  output logic       o_timeout
);

  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       cur_q, cur_d;
  logic [3:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       code_q, code_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;

  logic             pick_found;
  logic [3:0]       pick_idx;
  logic [4:0]       scan_sum;
  logic [3:0]       scan_idx;
  logic             rel_done, rel_wd, rel_to, release_now;

  // Scan channels starting at ptr and wrapping 9 -> 0; first requester wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = 4'd0;
    scan_sum   = 5'd0;
    scan_idx   = 4'd0;
    for (int i = 0; i < 10; i++) begin
      scan_sum = {1'b0, ptr_q} + 5'(i);
      if (scan_sum >= 5'd10) begin
        scan_sum = scan_sum - 5'd10;
      end
      scan_idx = scan_sum[3:0];
      if (!pick_found && i_req[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    rel_done    = i_done;
    rel_wd      = ~i_req[cur_q];
    rel_to      = (cnt_q == CNT_MAX);
    release_now = rel_done | rel_wd | rel_to;
  end

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    code_d    = code_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_en && pick_found) begin
          state_d = GRANT;
          cur_d   = pick_idx;
          cnt_d   = CNT_W'(1);
          code_d  = pick_idx + 4'd1;
          valid_d = 1'b1;
        end
      end
      GRANT: begin
        if (release_now) begin
          // Dropping to IDLE guarantees at least one code-0 cycle before the next grant.
          state_d   = IDLE;
          code_d    = 4'd0;
          valid_d   = 1'b0;
          cnt_d     = '0;
          ptr_d     = (cur_q == 4'd9) ? 4'd0 : cur_q + 4'd1;
          timeout_d = rel_to & ~rel_done & ~rel_wd;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        code_d  = 4'd0;
        valid_d = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      cur_q     <= 4'd0;
      ptr_q     <= 4'd0;
      cnt_q     <= '0;
      code_q    <= 4'd0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_code        = code_q;
  assign o_grant_valid = valid_q;
  assign o_timeout     = timeout_q;

endmodule

// File: tb/tb_decode_rr_scheduler.sv
// Bench for decode_rr_scheduler: directed scenarios plus random traffic, all scored
// against a channel-level round-robin model through an expected-output queue.
module tb_decode_rr_scheduler;

  localparam int MAX_HOLD = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [9:0] req;
  logic       done;
  logic [3:0] code;
  logic       gv;
  logic       to;

  always #5 clk = ~clk;

  decode_rr_scheduler #(.MAX_HOLD(MAX_HOLD)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_en         (en),
    .i_req        (req),
    .i_done       (done),
    .o_code       (code),
    .o_grant_valid(gv),
    .o_timeout    (to)
  );

  // Expected {timeout, valid, code} after each rising edge.
  logic [5:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: granted channel (-1 = none), cycles visible, rotation start.
  int m_cur = -1;
  int m_cnt = 0;
  int m_ptr = 0;
  bit m_to  = 1'b0;

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s @%0t: got to=%0b valid=%0b code=%0d, expected to=%0b valid=%0b code=%0d",
               name, $time, act[5], act[4], act[3:0], exp[5], exp[4], exp[3:0]);
    end
  endtask

  task automatic model_step(input bit r_n, input bit e, input logic [9:0] q, input bit d);
    bit wd, tmo;
    if (!r_n) begin
      m_cur = -1; m_cnt = 0; m_ptr = 0; m_to = 1'b0;
    end else if (m_cur < 0) begin
      m_to = 1'b0;
      if (e && q != 10'd0) begin
        for (int i = 0; i < 10; i++) begin
          int k;
          k = (m_ptr + i) % 10;
          if (m_cur < 0 && q[k]) begin
            m_cur = k;
            m_cnt = 1;
          end
        end
      end
    end else begin
      wd  = !q[m_cur];
      tmo = (m_cnt == MAX_HOLD);
      if (d || wd || tmo) begin
        m_to  = tmo && !d && !wd;
        m_ptr = (m_cur + 1) % 10;
        m_cur = -1;
        m_cnt = 0;
      end else begin
        m_to  = 1'b0;
        m_cnt = m_cnt + 1;
      end
    end
  endtask

  function automatic logic [5:0] model_out();
    logic [3:0] c;
    logic       v;
    v = (m_cur >= 0);
    c = v ? 4'(m_cur + 1) : 4'd0;
    return {m_to, v, c};
  endfunction

  task automatic drive_cycle(input bit r_n, input bit e, input logic [9:0] q, input bit d);
    @(negedge clk);
    rst_n = r_n; en = e; req = q; done = d;
    model_step(r_n, e, q, d);
    exp_q.push_back(model_out());
  endtask

  // Assert reset between edges and confirm the outputs clear without waiting for a clock.
  task automatic mid_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {to, gv, code}, 6'd0);
    model_step(1'b0, en, req, done);
    exp_q.push_back(model_out());
  endtask

  // Monitor: compare the DUT against the oldest expectation after every edge.
  initial begin
    logic [5:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("outputs", {to, gv, code}, e);
      end
    end
  end

  initial begin
    bit         hold_mode;
    logic [9:0] rq;
    rst_n = 1'b0; en = 1'b0; req = '0; done = 1'b0;

    repeat (3) drive_cycle(1'b0, 1'b0, 10'd0, 1'b0);

    // Single request on channel 3, done three edges later.
    drive_cycle(1'b1, 1'b1, 10'b0000001000, 1'b0);
    repeat (2) drive_cycle(1'b1, 1'b1, 10'b0000001000, 1'b0);
    drive_cycle(1'b1, 1'b1, 10'b0000001000, 1'b1);
    repeat (2) drive_cycle(1'b1, 1'b1, 10'd0, 1'b0);

    // Full rotation from a fresh pointer, done pulsed once per grant.
    drive_cycle(1'b0, 1'b0, 10'd0, 1'b0);
    for (int i = 0; i < 24; i++) drive_cycle(1'b1, 1'b1, 10'h3FF, (m_cur >= 0));

    // Channel 9 alone, never done: repeated forced releases.
    drive_cycle(1'b1, 1'b1, 10'd0, 1'b1);
    for (int i = 0; i < 40; i++) drive_cycle(1'b1, 1'b1, 10'h200, 1'b0);
    for (int i = 0; i < 4 && m_cur >= 0; i++) drive_cycle(1'b1, 1'b1, 10'h200, 1'b1);

    // After channel 9 releases, channel 0 wins over channel 9.
    for (int i = 0; i < 6; i++) drive_cycle(1'b1, 1'b1, 10'b1000000001, (m_cur >= 0));
    for (int i = 0; i < 2; i++) drive_cycle(1'b1, 1'b1, 10'd0, 1'b0);

    // Enable low blocks new grants but does not cut an active one.
    repeat (5) drive_cycle(1'b1, 1'b0, 10'h3FF, 1'b0);
    drive_cycle(1'b1, 1'b1, 10'h3FF, 1'b0);
    repeat (4) drive_cycle(1'b1, 1'b0, 10'h3FF, 1'b0);
    drive_cycle(1'b1, 1'b0, 10'h3FF, 1'b1);
    drive_cycle(1'b1, 1'b0, 10'h3FF, 1'b0);

    // Withdrawal of the granted channel's request.
    drive_cycle(1'b1, 1'b1, 10'h3FF, 1'b0);
    drive_cycle(1'b1, 1'b1, 10'h3FF, 1'b0);
    rq = 10'h3FF;
    if (m_cur >= 0) rq[m_cur] = 1'b0;
    drive_cycle(1'b1, 1'b1, rq, 1'b0);
    drive_cycle(1'b1, 1'b0, 10'd0, 1'b0);

    // Done arriving on the same edge as the hold limit: no timeout pulse.
    drive_cycle(1'b1, 1'b1, 10'h004, 1'b0);
    repeat (MAX_HOLD - 1) drive_cycle(1'b1, 1'b1, 10'h004, 1'b0);
    drive_cycle(1'b1, 1'b1, 10'h004, 1'b1);
    drive_cycle(1'b1, 1'b0, 10'd0, 1'b0);

    // Mid-grant asynchronous reset.
    drive_cycle(1'b1, 1'b1, 10'h080, 1'b0);
    drive_cycle(1'b1, 1'b1, 10'h080, 1'b0);
    mid_reset();
    drive_cycle(1'b0, 1'b1, 10'h080, 1'b0);

    // Random traffic, alternating between busy-done and long-hold phases.
    rq = 10'($urandom_range(0, 1023));
    hold_mode = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) hold_mode = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 4) == 0) rq = 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 249) == 0) begin
        mid_reset();
      end else begin
        drive_cycle(1'b1, ($urandom_range(0, 9) != 0), rq,
                    hold_mode ? 1'b0 : ($urandom_range(0, 7) == 0));
      end
    end
    repeat (2) drive_cycle(1'b1, 1'b0, 10'd0, 1'b0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left, required 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
